// File: rtl/mod_n_updown_counter.sv
// Runtime-modulus up/down counter with load, enable and a registered terminal-count pulse.
// Define MODN_WRAP_CNT_EN to add the WRAP_W-bit wrap-event counter and its wrap_cnt port.
module mod_n_updown_counter #(
  parameter int WIDTH = 4
`ifdef MODN_WRAP_CNT_EN
  , parameter int WRAP_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_n,
  output logic [WIDTH-1:0] count,
  output logic             tc
`ifdef MODN_WRAP_CNT_EN
  , output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  localparam int XW = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [XW-1:0]    w_mod;
  logic [XW-1:0]    w_mod_max;
  logic [XW-1:0]    w_cnt_x;
  logic [XW-1:0]    w_ld_x;
  logic [WIDTH:0]   w_step;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap;

  // Loaded values outside 0..M-1 are pinned to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [XW-1:0] val,
                                                  input logic [XW-1:0] m,
                                                  input logic [XW-1:0] m_max);
    if (val >= m) return WIDTH'(m_max);
    return WIDTH'(val);
  endfunction

  // Returns {wrap, next_count}; a count stranded above a lowered modulus wraps to 0.
  function automatic logic [WIDTH:0] step_up(input logic [XW-1:0] cnt,
                                             input logic [XW-1:0] m_max);
    if (cnt >= m_max) return {1'b1, WIDTH'(0)};
    return {1'b0, WIDTH'(cnt + XW'(1))};
  endfunction

  // Returns {wrap, next_count}; a stranded count re-enters at M-1 without a wrap.
  function automatic logic [WIDTH:0] step_dn(input logic [XW-1:0] cnt,
                                             input logic [XW-1:0] m,
                                             input logic [XW-1:0] m_max);
    if (cnt >= m)       return {1'b0, WIDTH'(m_max)};
    if (cnt == XW'(0))  return {1'b1, WIDTH'(m_max)};
    return {1'b0, WIDTH'(cnt - XW'(1))};
  endfunction

  // mod_n == 0 selects the full 2^WIDTH range; kept one bit wider so M-1 cannot overflow.
  assign w_mod     = (mod_n == '0) ? (XW'(1) << WIDTH) : {1'b0, mod_n};
  assign w_mod_max = w_mod - XW'(1);
  assign w_cnt_x   = {1'b0, r_count};
  assign w_ld_x    = {1'b0, load_val};

  always_comb begin
    w_step    = '0;
    w_wrap    = 1'b0;
    w_cnt_nxt = r_count;
    if (load) begin
      w_cnt_nxt = clamp_load(w_ld_x, w_mod, w_mod_max);
    end else if (en) begin
      w_step    = up_dn ? step_up(w_cnt_x, w_mod_max) : step_dn(w_cnt_x, w_mod, w_mod_max);
      w_wrap    = w_step[WIDTH];
      w_cnt_nxt = w_step[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_tc    <= w_wrap;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

`ifdef MODN_WRAP_CNT_EN
  logic [WRAP_W-1:0] r_wrap_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap) begin
      r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

endmodule
